low_pass_filter: RTL and testbench



---
 rtl/low_pass_filter_pkg.sv | 23 ++
 rtl/low_pass_filter_if.sv | 39 +++
 rtl/low_pass_filter_sat_shift_trunc.sv | 49 ++++
 rtl/low_pass_filter.sv | 99 +++++++++
 tb/tb_low_pass_filter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/low_pass_filter_pkg.sv
// -----------------------------------------------------------------------------
// low_pass_filter_pkg
// Shared constants for the PID signal-chain filter stages (low-pass, high-pass,
// PID). It holds the default sample and output widths, the default shift and
// saturation limits, and the running-sum width helper.
// No ports.
// -----------------------------------------------------------------------------
package low_pass_filter_pkg;

    localparam int LPF_IN_WIDTH    = 14;
    localparam int LPF_OUT_WIDTH   = 16;
    localparam int LPF_WINDOW_LOG2 = 4;
    localparam int LPF_OUT_SHIFT   = 4;
    localparam int LPF_MAX_OUT     = 32767;
    localparam int LPF_MIN_OUT     = -32768;

    // A sum of 2^window_log2 signed samples needs window_log2 extra bits to
    // stay exact.
    function automatic int sum_width(input int in_width, input int window_log2);
        return in_width + window_log2;
    endfunction

endpackage

// File: rtl/low_pass_filter_if.sv
// -----------------------------------------------------------------------------
// low_pass_filter_if
// Sample-stream and result bus of the boxcar low-pass filter.
//   master : upstream source / downstream consumer side
//            (drives sampleStrobeIn, inWire, clearIn)
//   slave  : the filter (drives outWire, outValid, primedOut, saturatedOut)
// Signals:
//   sampleStrobeIn  accept inWire this cycle
//   inWire          signed sample, IN_WIDTH bits
//   clearIn         synchronous flush of history/sum/count
//   outWire         signed filtered value, OUT_WIDTH bits, registered
//   outValid        one-cycle pulse, outWire updated
//   primedOut       window full since reset/clear
//   saturatedOut    outWire was clamped (qualified by outValid)
// -----------------------------------------------------------------------------
interface low_pass_filter_if
    import low_pass_filter_pkg::*;
#(
    parameter int IN_WIDTH  = LPF_IN_WIDTH,
    parameter int OUT_WIDTH = LPF_OUT_WIDTH
);
    logic                        sampleStrobeIn;
    logic signed [IN_WIDTH-1:0]  inWire;
    logic                        clearIn;
    logic signed [OUT_WIDTH-1:0] outWire;
    logic                        outValid;
    logic                        primedOut;
    logic                        saturatedOut;

    modport master (
        output sampleStrobeIn, inWire, clearIn,
        input  outWire, outValid, primedOut, saturatedOut
    );

    modport slave (
        input  sampleStrobeIn, inWire, clearIn,
        output outWire, outValid, primedOut, saturatedOut
    );
endinterface

// File: rtl/low_pass_filter_sat_shift_trunc.sv
// -----------------------------------------------------------------------------
// sat_shift_trunc
// Purely combinational. It applies an arithmetic right shift by OUT_SHIFT
// (floor toward -inf) and then clamps the result to [MIN_OUT, MAX_OUT].
// Ports:
//   sumIn       in   IN_W       signed running sum
//   valueOut    out  OUT_WIDTH  shifted and clamped value
//   clampedOut  out  1          valueOut was clamped
// -----------------------------------------------------------------------------
module sat_shift_trunc
    import low_pass_filter_pkg::*;
#(
    parameter int IN_W      = sum_width(LPF_IN_WIDTH, LPF_WINDOW_LOG2),
    parameter int OUT_WIDTH = LPF_OUT_WIDTH,
    parameter int OUT_SHIFT = LPF_OUT_SHIFT,
    parameter int MAX_OUT   = LPF_MAX_OUT,
    parameter int MIN_OUT   = LPF_MIN_OUT
) (
    input  logic signed [IN_W-1:0]      sumIn,
    output logic signed [OUT_WIDTH-1:0] valueOut,
    output logic                        clampedOut
);
    // Compare in a width that holds both the sum and the 32-bit limits
    // without losing their sign.
    localparam int CMP_W = ((IN_W > 32) ? IN_W : 32) + 1;

    localparam logic signed [CMP_W-1:0] CEIL  = CMP_W'(MAX_OUT);
    localparam logic signed [CMP_W-1:0] FLOOR = CMP_W'(MIN_OUT);

    logic signed [CMP_W-1:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        valueOut   = '0;
        clampedOut = 1'b0;
        shifted    = CMP_W'(sumIn) >>> OUT_SHIFT;
        if (shifted > CEIL) begin
            valueOut   = OUT_WIDTH'(CEIL);
            clampedOut = 1'b1;
        end else if (shifted < FLOOR) begin
            valueOut   = OUT_WIDTH'(FLOOR);
            clampedOut = 1'b1;
        end else begin
            valueOut   = OUT_WIDTH'(shifted);
        end
    end

endmodule

// File: rtl/low_pass_filter.sv
// -----------------------------------------------------------------------------
// low_pass_filter
// Strobe-gated boxcar (moving-average) filter. It keeps an exact running sum of
// the last 2^WINDOW_LOG2 accepted samples. Each accepted sample produces one
// shifted and saturated output two cycles after its strobe.
// Ports:
//   clkIn    in  rising-edge clock
//   rstIn_n  in  asynchronous active-low reset
//   bus      low_pass_filter_if.slave, which carries the sample strobe, sample,
//            clear, and the registered result/valid/primed/saturated outputs
// -----------------------------------------------------------------------------
module low_pass_filter
    import low_pass_filter_pkg::*;
#(
    parameter int IN_WIDTH    = LPF_IN_WIDTH,
    parameter int OUT_WIDTH   = LPF_OUT_WIDTH,
    parameter int WINDOW_LOG2 = LPF_WINDOW_LOG2,
    parameter int OUT_SHIFT   = LPF_OUT_SHIFT,
    parameter int MAX_OUT     = LPF_MAX_OUT,
    parameter int MIN_OUT     = LPF_MIN_OUT
) (
    input  logic              clkIn,
    input  logic              rstIn_n,
    low_pass_filter_if.slave  bus
);
    localparam int W     = 1 << WINDOW_LOG2;
    localparam int SUM_W = sum_width(IN_WIDTH, WINDOW_LOG2);
    localparam int CNT_W = WINDOW_LOG2 + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(W);

    logic signed [IN_WIDTH-1:0]  history [W];
    logic signed [SUM_W-1:0]     sum;
    logic [CNT_W-1:0]            count;
    logic                        pending;    // a stage-2 result is due next edge
    logic                        accept;
    logic signed [OUT_WIDTH-1:0] satValue;
    logic                        satFlag;

    assign accept = bus.sampleStrobeIn && !bus.clearIn;

    // Stage 1: history shift register, running sum and fill count.
    always_ff @(posedge clkIn or negedge rstIn_n) begin
        if (!rstIn_n) begin
            // NOTE: the history is reset like ordinary flops. It is not RAM,
            // and the running sum is only exact if history starts at zero.
            for (int i = 0; i < W; i++) history[i] <= '0;
            sum     <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else if (bus.clearIn) begin
            for (int i = 0; i < W; i++) history[i] <= '0;
            sum     <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage read pre-edge
            // values. The sum update below therefore sees the oldest sample
            // before the shift.
            pending <= accept;
            if (accept) begin
                history[0] <= bus.inWire;
                for (int i = 1; i < W; i++) history[i] <= history[i-1];
                sum <= sum + SUM_W'(bus.inWire) - SUM_W'(history[W-1]);
                if (count != FULL) count <= count + 1'b1;
            end
        end
    end

    assign bus.primedOut = (count == FULL);

    sat_shift_trunc #(
        .IN_W      (SUM_W),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SHIFT (OUT_SHIFT),
        .MAX_OUT   (MAX_OUT),
        .MIN_OUT   (MIN_OUT)
    ) u_sat_shift_trunc (
        .sumIn      (sum),
        .valueOut   (satValue),
        .clampedOut (satFlag)
    );

    // Stage 2: register the shaped sum. A clear in this cycle kills the
    // in-flight result, and outWire keeps its last value.
    always_ff @(posedge clkIn or negedge rstIn_n) begin
        if (!rstIn_n) begin
            bus.outWire      <= '0;
            bus.outValid     <= 1'b0;
            bus.saturatedOut <= 1'b0;
        end else begin
            bus.outValid <= pending && !bus.clearIn;
            if (pending && !bus.clearIn) begin
                bus.outWire      <= satValue;
                bus.saturatedOut <= satFlag;
            end
        end
    end

endmodule

// File: tb/tb_low_pass_filter.sv
// -----------------------------------------------------------------------------
// tb_low_pass_filter
// Drives two filters with the same stream: dut0 uses the defaults and dut1 uses
// OUT_SHIFT = 0. A window-of-samples reference model predicts every cycle of
// output for both.
// -----------------------------------------------------------------------------
module tb_low_pass_filter;
    import low_pass_filter_pkg::*;

    localparam int W = 1 << LPF_WINDOW_LOG2;

    logic clkIn   = 1'b0;
    logic rstIn_n = 1'b0;
    always #5 clkIn = ~clkIn;

    low_pass_filter_if bus0 ();
    low_pass_filter_if bus1 ();

    low_pass_filter #(.OUT_SHIFT(4)) dut0 (
        .clkIn   (clkIn),
        .rstIn_n (rstIn_n),
        .bus     (bus0.slave)
    );

    low_pass_filter #(.OUT_SHIFT(0)) dut1 (
        .clkIn   (clkIn),
        .rstIn_n (rstIn_n),
        .bus     (bus1.slave)
    );

    typedef struct {
        int due;
        int total;
    } pend_t;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    win [$];
    pend_t pend [$];
    bit    exp_valid = 1'b0;
    int    exp_total = 0;
    int    hold [2] = '{0, 0};
    int    shift_of [2] = '{4, 0};

    task automatic check(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Mean of the window scaled by 2^-sh, rounded toward -inf and clamped.
    function automatic int model_out(input int total, input int sh, output bit clamped);
        int d;
        int q;
        d = 1 << sh;
        if (total >= 0) q = total / d;
        else            q = -((-total + d - 1) / d);
        clamped = 1'b0;
        if (q > LPF_MAX_OUT) begin
            q = LPF_MAX_OUT;
            clamped = 1'b1;
        end else if (q < LPF_MIN_OUT) begin
            q = LPF_MIN_OUT;
            clamped = 1'b1;
        end
        return q;
    endfunction

    task automatic model_edge(input bit s, input int x, input bit c);
        int total;
        cyc++;
        exp_valid = 1'b0;
        if (c) begin
            win.delete();
            pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_valid = 1'b1;
                exp_total = pend[0].total;
                void'(pend.pop_front());
            end
            if (s) begin
                win.push_back(x);
                if (win.size() > W) void'(win.pop_front());
                total = 0;
                foreach (win[i]) total += win[i];
                pend.push_back('{cyc + 1, total});
            end
        end
    endtask

    task automatic compare_all();
        int o [2];
        bit v [2];
        bit p [2];
        bit s [2];
        bit clamped;
        int e;
        o[0] = int'(bus0.outWire); v[0] = bus0.outValid; p[0] = bus0.primedOut; s[0] = bus0.saturatedOut;
        o[1] = int'(bus1.outWire); v[1] = bus1.outValid; p[1] = bus1.primedOut; s[1] = bus1.saturatedOut;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d valid", d), int'(v[d]), int'(exp_valid));
            check($sformatf("d%0d primed", d), int'(p[d]), int'(win.size() == W));
            if (exp_valid) begin
                e = model_out(exp_total, shift_of[d], clamped);
                check($sformatf("d%0d out", d), o[d], e);
                check($sformatf("d%0d sat", d), int'(s[d]), int'(clamped));
                hold[d] = e;
            end else begin
                check($sformatf("d%0d hold", d), o[d], hold[d]);
            end
        end
    endtask

    task automatic drive(input bit s, input int x, input bit c);
        bus0.sampleStrobeIn = s;
        bus0.inWire         = x[LPF_IN_WIDTH-1:0];
        bus0.clearIn        = c;
        bus1.sampleStrobeIn = s;
        bus1.inWire         = x[LPF_IN_WIDTH-1:0];
        bus1.clearIn        = c;
    endtask

    task automatic cycle(input bit s, input int x, input bit c);
        drive(s, x, c);
        @(posedge clkIn);
        model_edge(s, x, c);
        @(negedge clkIn);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0);
    endtask

    task automatic async_reset();
        drive(1'b0, 0, 1'b0);
        #2 rstIn_n = 1'b0;
        #1;
        check("rst d0 out",    int'(bus0.outWire),      0);
        check("rst d0 valid",  int'(bus0.outValid),     0);
        check("rst d0 primed", int'(bus0.primedOut),    0);
        check("rst d0 sat",    int'(bus0.saturatedOut), 0);
        check("rst d1 out",    int'(bus1.outWire),      0);
        check("rst d1 valid",  int'(bus1.outValid),     0);
        win.delete();
        pend.delete();
        hold      = '{0, 0};
        exp_valid = 1'b0;
        @(posedge clkIn);
        @(negedge clkIn);
        rstIn_n = 1'b1;
        compare_all();
    endtask

    initial begin
        drive(1'b0, 0, 1'b0);
        rstIn_n = 1'b0;
        @(negedge clkIn);
        @(negedge clkIn);
        compare_all();
        rstIn_n = 1'b1;

        // DC fill
        for (int i = 0; i < 20; i++) cycle(1'b1, 100, 1'b0);
        idle(2);
        check("dc settled", int'(bus0.outWire), 100);

        // Impulses of both signs
        cycle(1'b0, 0, 1'b1);
        cycle(1'b1, 1000, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 0, 1'b0);
        cycle(1'b1, -1000, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 0, 1'b0);
        idle(2);

        // Saturation at both rails on the unshifted instance
        for (int i = 0; i < 18; i++) cycle(1'b1, 8191, 1'b0);
        check("sat ceil", int'(bus1.outWire), 32767);
        check("sat ceil flag", int'(bus1.saturatedOut), 1);
        for (int i = 0; i < 18; i++) cycle(1'b1, -8192, 1'b0);
        check("sat floor", int'(bus1.outWire), -32768);
        check("sat floor flag", int'(bus1.saturatedOut), 1);
        cycle(1'b0, 0, 1'b1);

        // Gapped strobes
        cycle(1'b1, 10, 1'b0); idle(3);
        cycle(1'b1, 20, 1'b0); idle(3);
        cycle(1'b1, 30, 1'b0); idle(3);
        check("gap last", int'(bus0.outWire), 3);

        // Clear colliding with a strobe after priming
        for (int i = 0; i < 16; i++) cycle(1'b1, 100, 1'b0);
        idle(2);
        cycle(1'b1, 500, 1'b1);
        idle(2);
        cycle(1'b1, 16, 1'b0);
        idle(2);
        check("clear refill", int'(bus0.outWire), 1);

        // Asynchronous reset with a result in flight, then refill
        for (int i = 0; i < 5; i++) cycle(1'b1, 100, 1'b0);
        async_reset();
        idle(2);
        for (int i = 0; i < 20; i++) cycle(1'b1, 100, 1'b0);
        idle(2);

        // Random stream with random gaps and occasional clears
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 16383)) - 8192,
                  ($urandom_range(0, 29) == 0));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
